// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M multiply/divide execute unit.
// Multiplies use a 32-step shift-add; divides use a 32-step restoring
// shift-subtract. Divide-by-zero, signed overflow and non-M ops finish in
// one cycle. Optional macro MULDIV_FAST_MUL_EN swaps the iterative multiply
// for a single-cycle 33x33 signed multiplier; divides are unaffected.
//
// state | meaning
// IDLE  | waiting for an op, in_ready high
// CALC  | one shift-add / shift-subtract step per cycle, cnt counts down
// DONE  | result presented, held until out_ready
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [4:0]       cnt;
    logic [2:0]       op_q;      // {is_div, fn[1:0]}
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      opa;       // |multiplicand|
    logic [31:0]      opb;       // |divisor|
    logic             neg;       // final result must be negated
    logic [63:0]      acc;       // mul: {hi, multiplier}; div: {rem, quotient}
    logic [31:0]      res;
    logic             vld;

    // Operand decode at issue: signedness, magnitudes, result sign.
    logic        is_m, rs1_sgn, rs2_sgn, a_neg, b_neg, neg_in;
    logic [31:0] abs_a, abs_b;

    assign is_m    = in_op[3] & ~in_op[4];
    assign rs1_sgn = in_op[2] ? ~in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
    assign rs2_sgn = in_op[2] ? ~in_op[0] : (in_op[1:0] == 2'b01);
    assign a_neg   = rs1_sgn & in_rs1[31];
    assign b_neg   = rs2_sgn & in_rs2[31];
    assign abs_a   = a_neg ? -in_rs1 : in_rs1;
    assign abs_b   = b_neg ? -in_rs2 : in_rs2;
    // Remainder follows the dividend; everything else follows the sign product.
    assign neg_in  = (in_op[2] & in_op[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fa, fb;
    logic signed [63:0] fprod;
    assign fa    = {rs1_sgn & in_rs1[31], in_rs1};
    assign fb    = {rs2_sgn & in_rs2[31], in_rs2};
    assign fprod = 64'(fa) * 64'(fb);
`endif

    // Single-cycle results: non-M ops, divide by zero, signed overflow.
    logic        fast_hit;
    logic [31:0] fast_res;
    always_comb begin
        fast_hit = 1'b0;
        fast_res = 32'd0;
        if (!is_m) begin
            fast_hit = 1'b1;
        end else if (in_op[2]) begin
            if (in_rs2 == 32'd0) begin
                fast_hit = 1'b1;
                fast_res = in_op[1] ? in_rs1 : 32'hFFFF_FFFF;
            end else if (!in_op[0] && in_rs1 == 32'h8000_0000 && in_rs2 == 32'hFFFF_FFFF) begin
                fast_hit = 1'b1;
                fast_res = in_op[1] ? 32'd0 : 32'h8000_0000;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            fast_hit = 1'b1;
            fast_res = (in_op[1:0] == 2'b00) ? fprod[31:0] : fprod[63:32];
        end
`endif
    end

    // One iteration step plus the sign-corrected result of the final step.
    logic [32:0] mul_sum, div_sh, div_dif;
    logic [63:0] acc_nxt, prod_fix;
    logic [31:0] div_sel, div_fix, calc_res;
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
        div_sh  = {acc[63:32], acc[31]};
        div_dif = div_sh - {1'b0, opb};
        acc_nxt = {mul_sum, acc[31:1]};
        if (op_q[2]) begin
            if (!div_dif[32])
                acc_nxt = {div_dif[31:0], acc[30:0], 1'b1};
            else
                acc_nxt = {div_sh[31:0], acc[30:0], 1'b0};
        end
        prod_fix = neg ? -acc_nxt : acc_nxt;
        div_sel  = op_q[1] ? acc_nxt[63:32] : acc_nxt[31:0];
        div_fix  = neg ? -div_sel : div_sel;
        if (op_q[2])
            calc_res = div_fix;
        else if (op_q[1:0] == 2'b00)
            calc_res = prod_fix[31:0];
        else
            calc_res = prod_fix[63:32];
    end

    // Control FSM and datapath registers; flush beats both accept and out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_q  <= 3'd0;
            tag_q <= '0;
            opa   <= 32'd0;
            opb   <= 32'd0;
            neg   <= 1'b0;
            acc   <= 64'd0;
            res   <= 32'd0;
            vld   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 5'd0;
            vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q  <= in_op[2:0];
                    tag_q <= in_tag;
                    opa   <= abs_a;
                    opb   <= abs_b;
                    neg   <= neg_in;
                    acc   <= {32'd0, in_op[2] ? abs_a : abs_b};
                    if (fast_hit) begin
                        res   <= fast_res;
                        vld   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt   <= 5'd31;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (cnt == 5'd0) begin
                        res   <= calc_res;
                        vld   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: if (out_ready) begin
                    vld   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign out_valid  = vld;
    assign out_result = res;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: stimulus pushes expected results
// from an arithmetic reference model, a negedge monitor pops and compares.
module tb_riscv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = 5'd0;
    logic [31:0] in_rs1 = 32'd0;
    logic [31:0] in_rs2 = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    riscv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [4:0] MUL = 5'b01000, MULH = 5'b01001, MULHSU = 5'b01010, MULHU = 5'b01011;
    localparam logic [4:0] DIV = 5'b01100, DIVU = 5'b01101, REM = 5'b01110, REMU = 5'b01111;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Reference model: plain 64-bit arithmetic over the RV32M rules.
    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb_;
        logic [63:0] ua, ub, p;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        p   = 64'd0;
        case (op)
            MUL:    begin p = sa * sb_; return p[31:0]; end
            MULH:   begin p = sa * sb_; return p[63:32]; end
            MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb_; return p[31:0];
            end
            REM: begin
                if (b == 32'd0) return a;
                p = sa % sb_; return p[31:0];
            end
            DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            REMU: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[4:3] != 2'b01) return 1;
        if (op[2]) begin
            if (b == 32'd0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Writeback back-pressure: 0 = always ready, 1 = random, 2 = stalled.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: latency at first valid, stability while stalled, compare on handshake.
    logic        prev_v = 1'b0;
    logic [31:0] prev_r = 32'd0;
    logic [4:0]  prev_t = 5'd0;
    int          lat_seen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_valid: got result %h tag %0d with nothing issued", out_result, out_tag);
                    end else begin
                        lat_seen = cyc + 1 - sb[0].acc;
                    end
                end else begin
                    chk("hold_result", out_result, prev_r);
                    chk("hold_tag", 32'(out_tag), 32'(prev_t));
                end
                if (out_ready && sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("latency", 32'(lat_seen), 32'(e.lat));
                end
            end
            prev_v = out_valid;
            prev_r = out_result;
            prev_t = out_tag;
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit track);
        int k;
        exp_t e;
        k = 0;
        @(posedge clk); #1;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            fail_now("issue_wait");
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        @(posedge clk); #1;
        if (track) begin
            e.res = ref_res(op, a, b);
            e.tag = tag;
            e.lat = ref_lat(op, a, b);
            e.acc = cyc;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        in_op    = 5'($urandom);
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_tag   = 5'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            fail_now("drain");
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int a0;
        logic [4:0] rop;
        logic [31:0] ra, rb;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        issue(MUL,    32'd7,          32'hFFFF_FFFD, 5'd1, 1'b1);
        issue(MULH,   32'd7,          32'hFFFF_FFFD, 5'd2, 1'b1);
        issue(MULHU,  32'd7,          32'hFFFF_FFFD, 5'd3, 1'b1);
        issue(DIV,    32'hFFFF_FFF9,  32'd2,         5'd4, 1'b1);
        issue(REM,    32'hFFFF_FFF9,  32'd2,         5'd5, 1'b1);
        issue(DIVU,   32'd100,        32'd7,         5'd6, 1'b1);
        issue(REMU,   32'd100,        32'd7,         5'd7, 1'b1);
        issue(DIVU,   32'd5,          32'd0,         5'd8, 1'b1);
        issue(REM,    32'd5,          32'd0,         5'd9, 1'b1);
        issue(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1'b1);
        issue(REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b1);
        issue(5'b00101, 32'd123,      32'd456,       5'd12, 1'b1);
        wait_done();

        // Back-pressure: stall writeback for 10 cycles after out_valid.
        rdy_mode = 2;
        issue(MULH, 32'h1234_5678, 32'h8765_4321, 5'd13, 1'b1);
        begin
            int k;
            k = 0;
            while (!out_valid && k < 100) begin @(negedge clk); k++; end
            if (!out_valid) fail_now("bp_wait_valid");
        end
        repeat (10) @(negedge clk);
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        rdy_mode = 0;
        wait_done();
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_busy_after", 32'(busy), 32'd0);

        // Flush a DIVU ten cycles after accept; nothing may come out.
        issue(DIVU, 32'hDEAD_BEEF, 32'd3, 5'd20, 1'b0);
        a0 = cyc;
        while (cyc < a0 + 9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (40) @(posedge clk);
        issue(MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd21, 1'b1);
        wait_done();

        // Flush together with an offered op: the op is dropped.
        in_valid = 1'b1; in_op = DIVU; in_rs1 = 32'd9; in_rs2 = 32'd0; in_tag = 5'd22;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 32'(busy), 32'd0);
        chk("flush_accept_valid", 32'(out_valid), 32'd0);
        repeat (5) @(posedge clk);

        // Reset in the middle of a divide.
        issue(DIVU, 32'd1000, 32'd3, 5'd23, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(REMU, 32'd1000, 32'd7, 5'd24, 1'b1);
        wait_done();

        // Randomized ops with random back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) rop = {2'b00, 3'($urandom)};
            else                           rop = {2'b01, 3'($urandom)};
            ra = pick_operand();
            rb = pick_operand();
            issue(rop, ra, rb, 5'($urandom), 1'b1);
        end
        wait_done();
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
